// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package reg_file_pkg;

  // Clear-sweep controller states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } rf_state_e;

  // Number of entries addressed by an addr_w-bit index.
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard: a producer reserves a register at issue,
// and the register's write-back clears it. Read ports see the pending bit,
// masked off when the value is being forwarded or the port is blanked.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int N_READ   = 2,
  parameter int N_WRITE  = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr_all,
  input  logic                      set_en,
  input  logic [ADDR_W-1:0]         set_addr,
  input  logic [N_WRITE-1:0]        clr_en,
  input  logic [N_WRITE*ADDR_W-1:0] clr_addr,
  input  logic [N_READ*ADDR_W-1:0]  raddr,
  input  logic [N_READ-1:0]         rd_mask,
  output logic [N_READ-1:0]         rpend
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Next pending vector: write-back clears, then a reservation on the same
  // edge overrides it, and the start of a clear sweep drops everything.
  always_comb begin
    // NOTE: every path starts from a full default, so no latch is inferred.
    pend_d = pend_q;
    for (int j = 0; j < N_WRITE; j++) begin
      if (clr_en[j]) pend_d[clr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (set_en) pend_d[set_addr] = 1'b1;
    if (clr_all) pend_d = '0;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  // Pending state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Per-port lookup of the pending bit.
  always_comb begin
    rpend = '0;
    for (int i = 0; i < N_READ; i++) begin
      rpend[i] = pend_q[raddr[i*ADDR_W +: ADDR_W]] & ~rd_mask[i];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file for the decode stage: N combinational read ports
// with optional same-cycle write forwarding, M prioritised write ports, a
// pending scoreboard for hazard detection and a one-entry-per-cycle clear sweep.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_READ   = 2,
  parameter int N_WRITE  = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_READ*ADDR_W-1:0]  raddr,
  output logic [N_READ*DATA_W-1:0]  rdata,
  output logic [N_READ-1:0]         rpend,
  input  logic [N_WRITE-1:0]        we,
  input  logic [N_WRITE*ADDR_W-1:0] waddr,
  input  logic [N_WRITE*DATA_W-1:0] wdata,
  input  logic                      rsv_en,
  input  logic [ADDR_W-1:0]         rsv_addr,
  input  logic                      clr_req,
  output logic                      ready,
  output logic                      clr_done
);

  localparam int                DEPTH    = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              ready_q;
  logic              clr_done_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              idle;
  logic [N_WRITE-1:0] wr_ok;
  logic [N_READ-1:0]  rd_mask;

  assign idle     = (state_q == ST_IDLE);
  assign ready    = ready_q;
  assign clr_done = clr_done_q;

  // A write is taken only while idle and never to the hard-wired zero entry.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < N_WRITE; j++) begin
      wr_ok[j] = we[j] & idle &
                 ~((ZERO_REG != 0) && (waddr[j*ADDR_W +: ADDR_W] == '0));
    end
  end

  // Storage array: prioritised writes while idle, one entry zeroed per sweep cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the array is reset explicitly because reset must leave every entry reading 0.
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (idle) begin
      // Later ports are scheduled last, so the highest index wins on equal addresses.
      for (int j = 0; j < N_WRITE; j++) begin
        if (wr_ok[j]) mem_q[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
      end
    end else begin
      mem_q[idx_q] <= '0;
    end
  end

  // Read muxes: array, then forwarded write data (highest port wins), then blanking.
  always_comb begin
    rdata   = '0;
    rd_mask = '0;
    for (int i = 0; i < N_READ; i++) begin
      rdata[i*DATA_W +: DATA_W] = mem_q[raddr[i*ADDR_W +: ADDR_W]];
      if (BYPASS != 0) begin
        for (int j = 0; j < N_WRITE; j++) begin
          if (wr_ok[j] && (waddr[j*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W])) begin
            rdata[i*DATA_W +: DATA_W] = wdata[j*DATA_W +: DATA_W];
            rd_mask[i]                = 1'b1;
          end
        end
      end
      if (!idle || ((ZERO_REG != 0) && (raddr[i*ADDR_W +: ADDR_W] == '0))) begin
        rdata[i*DATA_W +: DATA_W] = '0;
        rd_mask[i]                = 1'b1;
      end
    end
  end

  // Clear-sweep controller with registered ready and look-ahead clr_done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ready_q    <= 1'b1;
      clr_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          clr_done_q <= 1'b0;
          if (clr_req) begin
            state_q    <= ST_SWEEP;
            idx_q      <= '0;
            ready_q    <= 1'b0;
            clr_done_q <= (LAST_IDX == '0);
          end
        end
        ST_SWEEP: begin
          if (idx_q == LAST_IDX) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            clr_done_q <= 1'b0;
          end else begin
            idx_q      <= ADDR_W'(idx_q + 1'b1);
            clr_done_q <= (ADDR_W'(idx_q + 1'b1) == LAST_IDX);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ready_q    <= 1'b1;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .N_READ   (N_READ),
    .N_WRITE  (N_WRITE),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .clr_all  (idle & clr_req),
    .set_en   (idle & rsv_en),
    .set_addr (rsv_addr),
    .clr_en   (wr_ok),
    .clr_addr (waddr),
    .raddr    (raddr),
    .rd_mask  (rd_mask),
    .rpend    (rpend)
  );

endmodule
